// File: rtl/button_switch_conditioner_if.sv
// Signal bundle between the raw button/switch pins and the debounced front-end outputs.
// The slave side is the conditioner; the master side drives the raw inputs and consumes the outputs.
interface button_switch_conditioner_if;
  logic       button_raw;
  logic [7:0] switch_raw;
  logic       button_pulse;
  logic [7:0] switch_latched;
  logic       busy;

  modport master (
    output button_raw,
    output switch_raw,
    input  button_pulse,
    input  switch_latched,
    input  busy
  );

  modport slave (
    input  button_raw,
    input  switch_raw,
    output button_pulse,
    output switch_latched,
    output busy
  );
endinterface

// File: rtl/button_switch_conditioner.sv
// Push-button / slide-switch front-end: synchronises the raw pins, debounces the button and
// emits one press strobe per debounced press together with a switch snapshot.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | button released and qualified, waiting for a press
//  PRESS_CHK | button seen high, counting stable-high cycles
//  HELD      | press accepted and strobed, waiting for release
//  REL_CHK   | button seen low, counting stable-low cycles
module button_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input logic                          clk,
  input logic                          rst,
  button_switch_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_m;
  logic             btn_s;
  logic [7:0]       sw_m;
  logic [7:0]       sw_s;
  logic             button_pulse_q;
  logic [7:0]       switch_latched_q;
  logic             busy_q;

  // Two-flop synchronisers; nothing downstream ever looks at the raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 8'h00;
      sw_s  <= 8'h00;
    end else begin
      btn_m <= bus.button_raw;
      btn_s <= btn_m;
      sw_m  <= bus.switch_raw;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      button_pulse_q   <= 1'b0;
      switch_latched_q <= 8'h00;
      busy_q           <= 1'b0;
    end else begin
      button_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_CHK;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        PRESS_CHK: begin
          // Any low sample throws the whole qualification away; high time is not accumulated.
          if (!btn_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state            <= HELD;
            button_pulse_q   <= 1'b1;
            switch_latched_q <= sw_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.button_pulse   = button_pulse_q;
  assign bus.switch_latched = switch_latched_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_button_switch_conditioner.sv
// Bench for button_switch_conditioner: directed scenarios plus random bouncing, all checked
// against a run-length reference model of the debounce rules.
module tb_button_switch_conditioner;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  button_switch_conditioner_if bif ();

  button_switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a press is accepted after D+1 consecutive high synchronised samples,
  // a release after D+1 consecutive low samples; raw pins reach the logic two edges late.
  logic       m_b1, m_bs;
  logic [7:0] m_s1, m_ss;
  int         m_hi, m_lo;
  logic       m_pressed;
  logic       m_pulse;
  logic [7:0] m_latched;
  logic       m_busy;
  int         m_pulse_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b1 = 0; m_bs = 0; m_s1 = 0; m_ss = 0;
      m_hi = 0; m_lo = 0; m_pressed = 0; m_pulse = 0; m_latched = 0;
    end else begin
      m_pulse = 0;
      if (!m_pressed) begin
        m_hi = m_bs ? m_hi + 1 : 0;
        if (m_hi == D + 1) begin
          m_pulse = 1; m_pressed = 1; m_latched = m_ss; m_lo = 0;
          m_pulse_cnt++;
        end
      end else begin
        m_lo = m_bs ? 0 : m_lo + 1;
        if (m_lo == D + 1) begin
          m_pressed = 0; m_hi = 0;
        end
      end
      m_bs = m_b1; m_b1 = bif.button_raw;
      m_ss = m_s1; m_s1 = bif.switch_raw;
    end
    m_busy = m_pressed || (m_hi > 0);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.button_raw = 1'b0;
    bif.switch_raw = 8'h00;
    for (int k = 0; k < 3; k++) begin
      bif.button_raw = $urandom_range(1, 0);
      bif.switch_raw = 8'($urandom);
      cyc();
      n_checks++;
      if ({bif.button_pulse, bif.switch_latched, bif.busy} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got pulse=%b sw=%h busy=%b want 0/00/0",
                 k, bif.button_pulse, bif.switch_latched, bif.busy);
      end
    end
    bif.button_raw = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if ({bif.button_pulse, bif.switch_latched, bif.busy} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d got pulse=%b sw=%h busy=%b want 0/00/0",
                 k, bif.button_pulse, bif.switch_latched, bif.busy);
      end
    end
  endtask

  task automatic release_idle(input int n);
    bif.button_raw = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic test_latency();
    bif.switch_raw = 8'hB4;
    bif.button_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_checks++;
      if (bif.button_pulse !== (k == D + 2) || bif.busy !== (k >= 2) ||
          (k >= D + 2 && bif.switch_latched !== 8'hB4)) begin
        n_fail++;
        $display("FAIL latency edge=%0d got pulse=%b busy=%b sw=%h want pulse=%b busy=%b sw=b4",
                 k, bif.button_pulse, bif.busy, bif.switch_latched, k == D + 2, k >= 2);
      end
    end
    release_idle(10);
    n_checks++;
    if (bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_release got busy=%b want 0", bif.busy);
    end
  endtask

  task automatic test_press_bounce();
    int pat[6] = '{1, 1, 0, 1, 1, 0};
    int pulses = 0;
    for (int k = 0; k < 16; k++) begin
      bif.button_raw = (k < 6) ? pat[k][0] : 1'b0;
      cyc();
      if (bif.button_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL press_bounce got pulses=%0d busy=%b want 0 and 0", pulses, bif.busy);
    end
  endtask

  task automatic test_release_bounce();
    int pat[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
    int pulses = 0;
    for (int k = 0; k < 16; k++) begin
      bif.button_raw = pat[k][0];
      cyc();
      if (bif.button_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (bif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release_bounce_busy got busy=%b want 1", bif.busy);
    end
    bif.button_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bif.button_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_bounce got pulses=%0d busy=%b want 1 and 0", pulses, bif.busy);
    end
  endtask

  task automatic test_switch_hold();
    int seen = 0;
    bif.switch_raw = 8'h3C;
    bif.button_raw = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    bif.switch_raw = 8'hFF;
    release_idle(10);
    n_checks++;
    if (bif.switch_latched !== 8'h3C) begin
      n_fail++;
      $display("FAIL switch_hold_after_release got %h want 3c", bif.switch_latched);
    end
    bif.button_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bif.button_pulse === 1'b1) seen = 1;
      n_checks++;
      if (bif.switch_latched !== (seen ? 8'hFF : 8'h3C)) begin
        n_fail++;
        $display("FAIL switch_hold edge=%0d got %h want %h", k, bif.switch_latched,
                 seen ? 8'hFF : 8'h3C);
      end
    end
    release_idle(10);
  endtask

  task automatic test_reset_midpress();
    bif.button_raw = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bif.busy !== 1'b0 || bif.button_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midpress_async got busy=%b pulse=%b want 0/0", bif.busy, bif.button_pulse);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_checks++;
      if (bif.button_pulse !== (k == D + 2)) begin
        n_fail++;
        $display("FAIL reset_midpress edge=%0d got pulse=%b want %b", k, bif.button_pulse, k == D + 2);
      end
    end
    release_idle(10);
  endtask

  task automatic test_random();
    int start_pulses;
    int dut_pulses = 0;
    start_pulses = m_pulse_cnt;
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      bif.button_raw = $urandom_range(1, 0);
      bif.switch_raw = 8'($urandom);
      len = (seg % 4 == 0) ? $urandom_range(12, 5) : $urandom_range(4, 1);
      for (int k = 0; k < len; k++) begin
        cyc();
        if (bif.button_pulse === 1'b1) dut_pulses++;
        n_checks++;
        if (bif.button_pulse !== m_pulse || bif.switch_latched !== m_latched ||
            bif.busy !== m_busy) begin
          n_fail++;
          $display("FAIL random seg=%0d got pulse=%b sw=%h busy=%b want pulse=%b sw=%h busy=%b",
                   seg, bif.button_pulse, bif.switch_latched, bif.busy, m_pulse, m_latched, m_busy);
        end
      end
    end
    n_checks++;
    if (dut_pulses != m_pulse_cnt - start_pulses) begin
      n_fail++;
      $display("FAIL random_pulse_count got %0d want %0d", dut_pulses, m_pulse_cnt - start_pulses);
    end
    release_idle(10);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_pulse_cnt = 0;
    test_reset();
    test_latency();
    test_press_bounce();
    test_release_bounce();
    test_switch_hold();
    test_reset_midpress();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
